// File: rtl/vending_machine_param.sv
// vending_machine_param: parametrised multi-item vending controller.
// Accepts 1- and 2-unit coins into a saturating credit register, vends one of
// NUM_ITEMS products priced from PRICE_LIST, then pays change back serially as
// 2-unit and 1-unit pulses. A cancel refunds the whole credit the same way.
// Optional feature macro: VM_STOCK_EN adds per-item stock counters and the
// sold_out output; without it stock is unlimited and sold_out does not exist.
module vending_machine_param #(
    parameter int                                  CREDIT_W   = 4,
    parameter int                                  MAX_CREDIT = 15,
    parameter int                                  NUM_ITEMS  = 4,
    parameter int                                  SEL_W      = 2,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0]       PRICE_LIST = 16'h5432,
    parameter int                                  STOCK_INIT = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic                select,
    input  logic [SEL_W-1:0]    item_sel,
    input  logic                cancel,
    output logic                out,
    output logic [SEL_W-1:0]    item_out,
    output logic                change_1,
    output logic                change_2,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
`ifdef VM_STOCK_EN
    ,
    output logic                sold_out
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    localparam logic [CREDIT_W:0]   MAX_CREDIT_EXT = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] TWO_UNITS      = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] ZERO_UNITS     = '0;

`ifdef VM_STOCK_EN
    localparam int STOCK_W = (STOCK_INIT < 1) ? 1 : $clog2(STOCK_INIT + 1);
`endif

    // Registered state and outputs
    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_out;
    logic [SEL_W-1:0]    r_itemOut;
    logic                r_change1;
    logic                r_change2;
    logic                r_coinReject;
    logic                r_deny;
    logic                r_busy;

    // Next-state values
    logic [1:0]          w_stateNext;
    logic [CREDIT_W-1:0] w_creditNext;
    logic                w_outNext;
    logic [SEL_W-1:0]    w_itemNext;
    logic                w_change1Next;
    logic                w_change2Next;
    logic                w_coinRejectNext;
    logic                w_denyNext;

    // Coin arithmetic, one bit wider than credit so the limit check cannot wrap
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_creditSum;
    logic                w_coinAny;
    logic                w_coinFits;
    logic [CREDIT_W-1:0] w_creditPost;

    // Item decode
    logic                w_itemValid;
    logic [CREDIT_W-1:0] w_price;

    // Change pulse generation shared by VEND, CHANGE and the cancel path
    logic                w_doChange;
    logic [CREDIT_W-1:0] w_changeSrc;

`ifdef VM_STOCK_EN
    logic [STOCK_W-1:0]  r_stock [NUM_ITEMS];
    logic                r_soldOut;
    logic                w_soldOutNext;
    logic                w_stockEmpty;
    logic                w_vendAccept;
`endif

    // Post-coin credit: the whole cycle's coins are taken or refused together
    always_comb begin
        w_sum        = (CREDIT_W+1)'(coin_1) + ((CREDIT_W+1)'(coin_2) << 1);
        w_creditSum  = {1'b0, r_credit} + w_sum;
        w_coinAny    = coin_1 | coin_2;
        w_coinFits   = (w_creditSum <= MAX_CREDIT_EXT);
        w_creditPost = w_coinFits ? w_creditSum[CREDIT_W-1:0] : r_credit;
    end

    // Decode the selected item: validity, price and (optionally) stock level
    always_comb begin
        w_itemValid = 1'b0;
        w_price     = '0;
`ifdef VM_STOCK_EN
        w_stockEmpty = 1'b0;
`endif
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (int'(item_sel) == k) begin
                w_itemValid = 1'b1;
                w_price     = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
`ifdef VM_STOCK_EN
                w_stockEmpty = (r_stock[k] == '0);
`endif
            end
        end
    end

    // Next-state and next-output decision for the IDLE/VEND/CHANGE machine
    always_comb begin
        w_stateNext      = r_state;
        w_creditNext     = r_credit;
        w_outNext        = 1'b0;
        w_itemNext       = '0;
        w_change1Next    = 1'b0;
        w_change2Next    = 1'b0;
        w_coinRejectNext = 1'b0;
        w_denyNext       = 1'b0;
        w_doChange       = 1'b0;
        w_changeSrc      = '0;
`ifdef VM_STOCK_EN
        w_soldOutNext    = 1'b0;
        w_vendAccept     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_coinRejectNext = w_coinAny && !w_coinFits;
                w_creditNext     = w_creditPost;
                if (cancel && (w_creditPost != ZERO_UNITS)) begin
                    w_doChange  = 1'b1;
                    w_changeSrc = w_creditPost;
                end else if (select) begin
                    if (!w_itemValid || (w_creditPost < w_price)) begin
                        w_denyNext = 1'b1;
`ifdef VM_STOCK_EN
                    end else if (w_stockEmpty) begin
                        w_denyNext    = 1'b1;
                        w_soldOutNext = 1'b1;
`endif
                    end else begin
                        w_stateNext  = ST_VEND;
                        w_outNext    = 1'b1;
                        w_itemNext   = item_sel;
                        w_creditNext = w_creditPost - w_price;
`ifdef VM_STOCK_EN
                        w_vendAccept = 1'b1;
`endif
                    end
                end
            end
            ST_VEND, ST_CHANGE: begin
                w_coinRejectNext = w_coinAny;
                w_denyNext       = select;
                if (r_credit != ZERO_UNITS) begin
                    w_doChange  = 1'b1;
                    w_changeSrc = r_credit;
                end else begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext  = ST_IDLE;
                w_creditNext = '0;
            end
        endcase

        if (w_doChange) begin
            w_stateNext = ST_CHANGE;
            if (w_changeSrc >= TWO_UNITS) begin
                w_change2Next = 1'b1;
                w_creditNext  = w_changeSrc - TWO_UNITS;
            end else begin
                w_change1Next = 1'b1;
                w_creditNext  = '0;
            end
        end
    end

    // State, credit and every output register; reset aborts any transaction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_credit     <= '0;
            r_out        <= 1'b0;
            r_itemOut    <= '0;
            r_change1    <= 1'b0;
            r_change2    <= 1'b0;
            r_coinReject <= 1'b0;
            r_deny       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_credit     <= w_creditNext;
            r_out        <= w_outNext;
            r_itemOut    <= w_itemNext;
            r_change1    <= w_change1Next;
            r_change2    <= w_change2Next;
            r_coinReject <= w_coinRejectNext;
            r_deny       <= w_denyNext;
            r_busy       <= (w_stateNext != ST_IDLE);
        end
    end

`ifdef VM_STOCK_EN
    // Per-item stock counters, decremented by each accepted vend
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_soldOut <= 1'b0;
            for (int k = 0; k < NUM_ITEMS; k++) begin
                r_stock[k] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            r_soldOut <= w_soldOutNext;
            for (int k = 0; k < NUM_ITEMS; k++) begin
                if (w_vendAccept && (int'(item_sel) == k)) begin
                    r_stock[k] <= r_stock[k] - STOCK_W'(1);
                end
            end
        end
    end

    assign sold_out = r_soldOut;
`endif

    assign out         = r_out;
    assign item_out    = r_itemOut;
    assign change_1    = r_change1;
    assign change_2    = r_change2;
    assign coin_reject = r_coinReject;
    assign deny        = r_deny;
    assign busy        = r_busy;
    assign credit      = r_credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed bench for vending_machine_param.
// A default-parameter instance covers the main behaviour; a second instance
// with NUM_ITEMS=3 covers the out-of-range item index.
// Define VM_STOCK_EN on both bench and design to exercise the stock feature.
module tb_vending_machine_param;

    logic       clock;
    logic       reset;

    logic       coin_1, coin_2, select, cancel;
    logic [1:0] item_sel;
    logic       out, change_1, change_2, coin_reject, deny, busy;
    logic [1:0] item_out;
    logic [3:0] credit;

    logic       d3Coin1, d3Coin2, d3Select, d3Cancel;
    logic [1:0] d3ItemSel;
    logic       d3Out, d3Change1, d3Change2, d3CoinReject, d3Deny, d3Busy;
    logic [1:0] d3ItemOut;
    logic [3:0] d3Credit;

`ifdef VM_STOCK_EN
    logic       sold_out;
    logic       d3SoldOut;
`endif

    int compared;
    int mismatched;
    logic [11:0] expVec;

    vending_machine_param dut (
        .clock      (clock),
        .reset      (reset),
        .coin_1     (coin_1),
        .coin_2     (coin_2),
        .select     (select),
        .item_sel   (item_sel),
        .cancel     (cancel),
        .out        (out),
        .item_out   (item_out),
        .change_1   (change_1),
        .change_2   (change_2),
        .coin_reject(coin_reject),
        .deny       (deny),
        .busy       (busy),
        .credit     (credit)
`ifdef VM_STOCK_EN
        ,
        .sold_out   (sold_out)
`endif
    );

    vending_machine_param #(
        .CREDIT_W  (4),
        .MAX_CREDIT(15),
        .NUM_ITEMS (3),
        .SEL_W     (2),
        .PRICE_LIST(12'h432),
        .STOCK_INIT(3)
    ) dut3 (
        .clock      (clock),
        .reset      (reset),
        .coin_1     (d3Coin1),
        .coin_2     (d3Coin2),
        .select     (d3Select),
        .item_sel   (d3ItemSel),
        .cancel     (d3Cancel),
        .out        (d3Out),
        .item_out   (d3ItemOut),
        .change_1   (d3Change1),
        .change_2   (d3Change2),
        .coin_reject(d3CoinReject),
        .deny       (d3Deny),
        .busy       (d3Busy),
        .credit     (d3Credit)
`ifdef VM_STOCK_EN
        ,
        .sold_out   (d3SoldOut)
`endif
    );

    // Free-running clock, period 10
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pack the main instance outputs for one-shot comparison
    function automatic logic [11:0] obsMain();
        return {out, item_out, change_1, change_2, coin_reject, deny, busy, credit};
    endfunction

    // Pack the NUM_ITEMS=3 instance outputs
    function automatic logic [11:0] obsD3();
        return {d3Out, d3ItemOut, d3Change1, d3Change2, d3CoinReject, d3Deny, d3Busy, d3Credit};
    endfunction

    // Build an expected output vector in the same field order
    function automatic logic [11:0] mk(input logic o, input logic [1:0] it, input logic c1,
                                       input logic c2, input logic rj, input logic dn,
                                       input logic bz, input logic [3:0] cr);
        return {o, it, c1, c2, rj, dn, bz, cr};
    endfunction

    // Drive one cycle of main-instance inputs; outputs are sampled 1 after the edge
    task automatic applyStimulus(input logic c1, input logic c2, input logic sel,
                                 input logic [1:0] isel, input logic canc);
        @(negedge clock);
        coin_1 = c1; coin_2 = c2; select = sel; item_sel = isel; cancel = canc;
        @(posedge clock);
        #1;
        coin_1 = 1'b0; coin_2 = 1'b0; select = 1'b0; item_sel = 2'd0; cancel = 1'b0;
    endtask

    // Same for the NUM_ITEMS=3 instance
    task automatic applyStimulus3(input logic c1, input logic c2, input logic sel,
                                  input logic [1:0] isel, input logic canc);
        @(negedge clock);
        d3Coin1 = c1; d3Coin2 = c2; d3Select = sel; d3ItemSel = isel; d3Cancel = canc;
        @(posedge clock);
        #1;
        d3Coin1 = 1'b0; d3Coin2 = 1'b0; d3Select = 1'b0; d3ItemSel = 2'd0; d3Cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL reset_hold: got %b need %b", obsMain(), expVec);
        end
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        compared++;
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL reset_release: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_purchase_exact();
        applyStimulus(1, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 1);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL exact_coin1: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 1, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 3);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL exact_coin2: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 1, 2'd1, 0);
        compared++; expVec = mk(1, 1, 0, 0, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL exact_vend: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL exact_idle: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_change();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 6);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL change_credit6: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 1, 2'd0, 0);
        compared++; expVec = mk(1, 0, 0, 0, 0, 0, 1, 4);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL change_vend: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 2);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL change_pulse1: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL change_pulse2: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL change_idle: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_cancel();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 3);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL cancel_pulse1: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 1);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL cancel_pulse2: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 1, 0, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL cancel_pulse3: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL cancel_idle: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 1);
        compared++;
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL cancel_zero: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 14);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_credit14: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 1, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 1, 0, 0, 14);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_reject2: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(1, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 15);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_fill15: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(1, 1, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 1, 0, 0, 15);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_reject3: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 1);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 13);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_refund: got %b need %b", obsMain(), expVec);
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL sat_drained: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_deny();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd3, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 1, 0, 4);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL deny_short: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 1);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 2);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL deny_refund: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(1, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 1, 1, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL deny_coin_in_change: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 1, 2'd0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 1, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL deny_select_busy: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 1, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL deny_coin_in_vend: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_same_cycle();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 2'd1, 0);
        compared++; expVec = mk(1, 1, 0, 0, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL same_coin_select: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        compared++; expVec = mk(0, 0, 1, 0, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL same_coin_cancel: got %b need %b", obsMain(), expVec);
        end
        applyStimulus(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL same_idle: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_bad_index();
        for (int i = 0; i < 3; i++) applyStimulus3(0, 1, 0, 0, 0);
        applyStimulus3(0, 0, 1, 2'd3, 0);
        compared++; expVec = mk(0, 0, 0, 0, 0, 1, 0, 6);
        if (obsD3() !== expVec) begin
            mismatched++; $display("[TB] FAIL bad_index_deny: got %b need %b", obsD3(), expVec);
        end
        applyStimulus3(0, 0, 1, 2'd2, 0);
        compared++; expVec = mk(1, 2, 0, 0, 0, 0, 1, 2);
        if (obsD3() !== expVec) begin
            mismatched++; $display("[TB] FAIL d3_vend_item2: got %b need %b", obsD3(), expVec);
        end
        applyStimulus3(0, 0, 0, 0, 0);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 0);
        if (obsD3() !== expVec) begin
            mismatched++; $display("[TB] FAIL d3_change: got %b need %b", obsD3(), expVec);
        end
    endtask

    task automatic test_reset_mid_change();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        compared++; expVec = mk(0, 0, 0, 1, 0, 0, 1, 4);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL midreset_pre: got %b need %b", obsMain(), expVec);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++; expVec = mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL midreset_async: got %b need %b", obsMain(), expVec);
        end
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        compared++;
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL midreset_after: got %b need %b", obsMain(), expVec);
        end
    endtask

    task automatic test_stock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            applyStimulus(0, 0, 1, 2'd0, 0);
            compared++; expVec = mk(1, 0, 0, 0, 0, 0, 1, 0);
            if (obsMain() !== expVec) begin
                mismatched++; $display("[TB] FAIL stock_vend%0d: got %b need %b", i, obsMain(), expVec);
            end
            applyStimulus(0, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'd0, 0);
`ifdef VM_STOCK_EN
        compared++; expVec = mk(0, 0, 0, 0, 0, 1, 0, 2);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL stock_fourth: got %b need %b", obsMain(), expVec);
        end
        compared++;
        if (sold_out !== 1'b1) begin
            mismatched++; $display("[TB] FAIL stock_sold_out: got %b need 1", sold_out);
        end
`else
        compared++; expVec = mk(1, 0, 0, 0, 0, 0, 1, 0);
        if (obsMain() !== expVec) begin
            mismatched++; $display("[TB] FAIL stock_unlimited: got %b need %b", obsMain(), expVec);
        end
`endif
    endtask

    // Run every scenario in order, then report
    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b1;
        coin_1 = 1'b0; coin_2 = 1'b0; select = 1'b0; item_sel = 2'd0; cancel = 1'b0;
        d3Coin1 = 1'b0; d3Coin2 = 1'b0; d3Select = 1'b0; d3ItemSel = 2'd0; d3Cancel = 1'b0;
        test_reset();
        test_purchase_exact();
        test_change();
        test_cancel();
        test_saturation();
        test_deny();
        test_same_cycle();
        test_bad_index();
        test_reset_mid_change();
        test_stock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the fixed-price two-coin vending FSM.
- Accepts 1- and 2-unit coins into a saturating credit register. Supports NUM_ITEMS selectable products, each with its own price from a packed parameter.
- Vends one item per purchase, then returns change serially as 2-unit and 1-unit pulses. A cancel refunds all credit.
- Sits between the coin acceptor/keypad front end and the dispenser/change-hopper drivers.

Parameters:
- CREDIT_W, 4: credit and price width in units.
- MAX_CREDIT, 15: highest credit accepted; must be ≤ 2^CREDIT_W−1.
- NUM_ITEMS, 4: number of products.
- SEL_W, 2: item_sel width; must satisfy 2^SEL_W ≥ NUM_ITEMS.
- PRICE_LIST, 16'h5432: NUM_ITEMS×CREDIT_W packed prices, item 0 in the LSBs. Defaults: item0=2, item1=3, item2=4, item3=5. Every price must be ≥ 1.
- STOCK_INIT, 3: initial stock per item; used only with VM_STOCK_EN.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- coin_1  in  1  1-unit coin, single-cycle pulse.
- coin_2  in  1  2-unit coin, single-cycle pulse; may coincide with coin_1 (worth 3).
- select  in  1  purchase request pulse.
- item_sel  in  SEL_W  item index, sampled with select.
- cancel  in  1  refund request pulse.
- out  out  1  vend pulse, one cycle.
- item_out  out  SEL_W  vended index; valid while out=1, otherwise 0.
- change_1  out  1  one 1-unit change pulse.
- change_2  out  1  one 2-unit change pulse.
- coin_reject  out  1  one-cycle pulse: the coins of the previous cycle were refused.
- deny  out  1  one-cycle pulse: select refused (bad index, insufficient credit, or sold out).
- busy  out  1  high in VEND and CHANGE.
- credit  out  CREDIT_W  current credit or remaining change.
- sold_out  out  1  VM_STOCK_EN only; one-cycle pulse.

Behaviour:
- All outputs are registered. On reset, state=IDLE and every output is 0. Reset asserted mid-vend or mid-change aborts immediately; credit is lost.
- States: IDLE, VEND, CHANGE.
- IDLE, coins: sum = coin_1 + 2·coin_2.
  - If credit+sum ≤ MAX_CREDIT: credit += sum.
  - Otherwise the whole cycle's coins are refused: coin_reject=1 next cycle, credit unchanged.
- IDLE, evaluation order within a cycle: coin acceptance first, then cancel, then select. The select/cancel decision uses the post-coin credit (credit'). Cancel has priority over select.
- IDLE, cancel:
  - credit' > 0 → CHANGE.
  - credit' = 0 → no effect.
- IDLE, select:
  - Accepted when item_sel < NUM_ITEMS and credit' ≥ price[item_sel] → VEND; credit ← credit' − price.
  - Otherwise deny=1 next cycle and credit is kept.
- VEND lasts exactly one cycle:
  - out=1 and item_out=index in the first cycle after the accepting select.
  - Next state: credit > 0 → CHANGE, else IDLE.
- CHANGE, one pulse per cycle:
  - credit ≥ 2 → change_2=1, credit −= 2.
  - credit = 1 → change_1=1, credit = 0.
  - Return to IDLE in the cycle after the last pulse.
- Latency: the first change pulse comes the cycle after out. A refund's first pulse comes the cycle after cancel.
- In VEND or CHANGE:
  - Coins → coin_reject next cycle, credit unaffected.
  - select → deny.
  - cancel → ignored.
- Arithmetic: the credit+sum compare uses CREDIT_W+1 bits, so there is no wrap-around.

Optional Feature:
- Macro: VM_STOCK_EN.
- With it defined:
  - Each item has a stock counter initialised to STOCK_INIT on reset.
  - An accepted vend decrements that item's counter.
  - A select with sufficient credit on an item with stock 0 gives sold_out=1 and deny=1 next cycle; credit is kept.
  - The sold_out port exists.
- Without it: stock is unlimited, and both the sold_out port and the counters are absent.

Test Plan:
- coin_1, then coin_2 (credit=3), then select item_sel=1 → out=1 and item_out=1 the next cycle; no change pulses; credit=0; back to IDLE.
- coin_2 ×3 (credit=6), select item 0 → out, then change_2 on each of the next two cycles; credit 4→2→0; then IDLE.
- credit=5, cancel → change_2, change_2, change_1 on consecutive cycles; busy high throughout; credit ends at 0.
- credit=14: coin_2 → coin_reject=1, credit stays 14. Then coin_1 → credit=15. Then coin_1+coin_2 in the same cycle → coin_reject=1, credit stays 15.
- Denials:
  - credit=4, select item 3 (price 5) → deny=1, credit stays 4.
  - Select with item_sel=3 when NUM_ITEMS=3 → deny=1.
  - Coin arriving during CHANGE → coin_reject=1.
- Reset and stock:
  - Reset asserted mid-CHANGE → all outputs 0 asynchronously, without a clock edge.
  - With VM_STOCK_EN and STOCK_INIT=3: four purchases of item 0 at credit 2 each → the fourth gives sold_out=1 and deny=1, credit stays 2.
